// File: rtl/taxi_pcie_cfg_mgmt_target_pkg.sv
// Shared types and constants for the PCIe config-management target.
package taxi_pcie_cfg_mgmt_target_pkg;

  localparam logic [15:0] DEF_VENDOR_ID = 16'h1234;
  localparam logic [15:0] DEF_DEVICE_ID = 16'hC001;
  localparam int unsigned CNT_W         = 4;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE, ST_HOLD} state_e;
  typedef enum logic [1:0] {OP_RD, OP_WR, OP_ERR} op_e;

  typedef struct packed {
    op_e         op;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

endpackage

// File: rtl/taxi_cfg_mgmt_regfile.sv
// Byte-enabled single-port dword RAM; dword 0 of every function reads a fixed ID word.
module taxi_cfg_mgmt_regfile #(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned REGS    = 64,
  parameter int unsigned AW      = 6,
  parameter logic [31:0] RO_WORD = 32'h0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] idx_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  localparam int unsigned RA = $clog2(REGS);

  logic [DEPTH-1:0][31:0] mem_q;
  logic                   ro;

  // Function stride is a power of two, so the low index bits are the dword address.
  assign ro      = (idx_i[RA-1:0] == '0);
  assign rdata_o = ro ? RO_WORD : mem_q[idx_i];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else if (we_i && !ro) begin
      for (int b = 0; b < 4; b++)
        if (be_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
  end

endmodule

// File: rtl/taxi_pcie_cfg_mgmt_target.sv
// Config-management target: fixed-latency read/write of per-function config dwords.
module taxi_pcie_cfg_mgmt_target
  import taxi_pcie_cfg_mgmt_target_pkg::*;
#(
  parameter int unsigned FUNCS     = 1,
  parameter int unsigned REGS      = 64,
  parameter int unsigned LATENCY   = 4,
  parameter logic [15:0] VENDOR_ID = DEF_VENDOR_ID,
  parameter logic [15:0] DEVICE_ID = DEF_DEVICE_ID
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  cfg_mgmt_addr,
  input  logic [7:0]  cfg_mgmt_function_number,
  input  logic        cfg_mgmt_write,
  input  logic [31:0] cfg_mgmt_write_data,
  input  logic [3:0]  cfg_mgmt_byte_enable,
  input  logic        cfg_mgmt_read,
  output logic [31:0] cfg_mgmt_read_data,
  output logic        cfg_mgmt_read_write_done,
  output logic        err_unsupported,
  output logic        busy
);

  localparam int unsigned RA = $clog2(REGS);
  localparam int unsigned AW = $clog2(FUNCS * REGS);

  logic [1:0]       rst_sync_q;
  logic             run;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  req_t             req_q, req_in, req_n;
  logic [AW-1:0]    idx_q, idx_in, idx_n;
  logic             addr_ok, func_ok, accept, rf_we;
  logic [31:0]      rf_rdata, rdata_q;
  logic             done_q, err_q, busy_q;

  // Requests are only accepted once the released reset has crossed two flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign run = rst_sync_q[1];

  assign addr_ok = (32'(cfg_mgmt_addr) < REGS);
  assign func_ok = (32'(cfg_mgmt_function_number) < FUNCS);

  always_comb begin
    req_in.wdata = cfg_mgmt_write_data;
    req_in.be    = cfg_mgmt_byte_enable;
    if ((cfg_mgmt_read && cfg_mgmt_write) || !addr_ok || !func_ok) req_in.op = OP_ERR;
    else if (cfg_mgmt_write)                                       req_in.op = OP_WR;
    else                                                           req_in.op = OP_RD;
    idx_in = (req_in.op == OP_ERR) ? '0 :
             AW'(cfg_mgmt_function_number) * AW'(REGS) + AW'(cfg_mgmt_addr[RA-1:0]);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: if (run && (cfg_mgmt_read || cfg_mgmt_write)) begin
        cnt_d   = CNT_W'(LATENCY - 1);
        state_d = (LATENCY == 1) ? ST_DONE : ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_d == '0) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_HOLD;
      ST_HOLD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // With LATENCY=1 the accept and the done-load share an edge, so look through the capture.
  assign accept = (state_q == ST_IDLE) && (state_d != ST_IDLE);
  assign req_n  = accept ? req_in : req_q;
  assign idx_n  = accept ? idx_in : idx_q;
  assign rf_we  = (state_q == ST_DONE) && (req_q.op == OP_WR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        req_q <= req_in;
        idx_q <= idx_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      done_q <= (state_d == ST_DONE);
      err_q  <= (state_d == ST_DONE) && (req_n.op == OP_ERR);
      busy_q <= (state_d != ST_IDLE);
      if (state_d == ST_DONE) rdata_q <= (req_n.op == OP_ERR) ? '0 : rf_rdata;
    end
  end

  taxi_cfg_mgmt_regfile #(
    .DEPTH   (FUNCS * REGS),
    .REGS    (REGS),
    .AW      (AW),
    .RO_WORD ({DEVICE_ID, VENDOR_ID})
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (rf_we),
    .be_i    (req_q.be),
    .idx_i   (idx_n),
    .wdata_i (req_q.wdata),
    .rdata_o (rf_rdata)
  );

  assign cfg_mgmt_read_data       = rdata_q;
  assign cfg_mgmt_read_write_done = done_q;
  assign err_unsupported          = err_q;
  assign busy                     = busy_q;

endmodule
